// File: rtl/pov_column_sequencer.sv
// POV column sequencer: measures the rotation period from the index sensor,
// splits each revolution into NCOLS equal slots and streams one 16-bit image
// column per slot to the LED output stage with a one-cycle load strobe.
// Optional feature macro: POV_REVERSE_DIR_EN (adds the dir input; dir=1 issues
// columns in descending order).
module pov_column_sequencer #(
    parameter int unsigned NCOLS    = 64,
    parameter int unsigned CW       = 6,
    parameter int unsigned PW       = 24,
    parameter int unsigned MIN_SLOT = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          index,
    input  logic [3:0]    t_cfg,
`ifdef POV_REVERSE_DIR_EN
    input  logic          dir,
`endif
    input  logic          wr_en,
    input  logic [CW-1:0] wr_addr,
    input  logic [15:0]   wr_data,
    output logic [15:0]   leds,
    output logic          load_leds,
    output logic [3:0]    T,
    output logic [CW-1:0] col_idx,
    output logic          period_valid
);

    // Slot length is at most (2^PW) >> CW, so PW+1-CW bits always suffice.
    localparam int unsigned SW = PW + 1 - CW;

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StMeasure = 2'd1;
    localparam logic [1:0] StRun     = 2'd2;

    localparam logic [CW-1:0] LastCol = CW'(NCOLS - 1);

    logic          idx_s1, idx_s2, idx_d;
    logic          ev;
    logic [PW-1:0] per_cnt;
    logic          sat;
    logic [SW-1:0] len_new;
    logic          qual;
    logic [1:0]    state;
    logic [SW-1:0] slot_len, slot_cnt;
    logic          slot_end;
    logic [CW-1:0] col_k;
    logic          start, adv, to_idle, issue;
    logic [CW-1:0] issue_k, issue_addr;
    logic          dir_sel;
    logic [15:0]   mem [NCOLS];

`ifdef POV_REVERSE_DIR_EN
    logic dir_q;
`endif

    assign ev       = idx_s2 & ~idx_d;
    assign sat      = (per_cnt == {PW{1'b1}});
    // Cycles since the previous event is per_cnt+1; slot length is that over NCOLS.
    assign len_new  = SW'(({1'b0, per_cnt} + {{PW{1'b0}}, 1'b1}) >> CW);
    assign qual     = (len_new >= SW'(MIN_SLOT));
    assign slot_end = (slot_cnt == slot_len - SW'(1));

    assign start   = ev && qual && (state == StMeasure || state == StRun);
    assign adv     = (state == StRun) && !ev && !sat && (col_k != LastCol) && slot_end;
    assign to_idle = (state != StIdle) && !ev && sat;
    assign issue   = start || adv;
    assign issue_k = start ? '0 : col_k + CW'(1);

`ifdef POV_REVERSE_DIR_EN
    assign dir_sel = start ? dir : dir_q;
`else
    assign dir_sel = 1'b0;
`endif
    // NCOLS is a power of two, so NCOLS-1-k is the bitwise inverse of k.
    assign issue_addr = dir_sel ? ~issue_k : issue_k;

    assign period_valid = (state == StRun);

    // Index synchronizer, edge-detect delay flop and saturating period counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_s1  <= 1'b0;
            idx_s2  <= 1'b0;
            idx_d   <= 1'b0;
            per_cnt <= '0;
        end else begin
            idx_s1 <= index;
            idx_s2 <= idx_s1;
            idx_d  <= idx_s2;
            if (ev) begin
                per_cnt <= '0;
            end else if (!sat) begin
                per_cnt <= per_cnt + PW'(1);
            end
        end
    end

    // State machine, revolution parameters and slot/column counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= StIdle;
            slot_len <= '0;
            slot_cnt <= '0;
            col_k    <= '0;
            T        <= 4'd0;
`ifdef POV_REVERSE_DIR_EN
            dir_q    <= 1'b0;
`endif
        end else if (start) begin
            state    <= StRun;
            slot_len <= len_new;
            T        <= t_cfg;
            slot_cnt <= '0;
            col_k    <= '0;
`ifdef POV_REVERSE_DIR_EN
            dir_q    <= dir;
`endif
        end else if (to_idle) begin
            state <= StIdle;
        end else begin
            case (state)
                StIdle: begin
                    if (ev) state <= StMeasure;
                end
                StMeasure: begin
                end
                StRun: begin
                    if (ev) begin
                        // Non-qualifying index while running: stop emitting.
                        state <= StMeasure;
                    end else if (col_k != LastCol) begin
                        if (slot_end) begin
                            slot_cnt <= '0;
                            col_k    <= col_k + CW'(1);
                        end else begin
                            slot_cnt <= slot_cnt + SW'(1);
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    // Registered column read: strobe, pattern and column number appear together.
    always_ff @(posedge clk) begin
        if (rst) begin
            leds      <= 16'h0000;
            load_leds <= 1'b0;
            col_idx   <= '0;
        end else begin
            load_leds <= issue;
            if (issue) begin
                leds    <= mem[issue_addr];
                col_idx <= issue_addr;
            end else if (to_idle) begin
                col_idx <= '0;
            end
        end
    end

    // Image RAM write port; not touched by reset, read returns old data on collision.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

endmodule

// File: tb/tb_pov_column_sequencer.sv
// Self-checking bench for pov_column_sequencer with NCOLS=8, CW=3, PW=16, MIN_SLOT=4.
module tb_pov_column_sequencer;

    typedef struct packed {
        logic [31:0] c;
        logic [15:0] leds;
        logic [2:0]  col;
        logic [3:0]  t;
        logic        pv;
    } strobe_t;

    // One revolution per record: index gap that follows the rise, t_cfg, and the
    // strobes expected inside that gap (count, spacing) plus period_valid at its end.
    typedef struct {
        int         gap;
        logic [3:0] tcfg;
        int         n;
        int         len;
        logic       pv;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst, index, wr_en;
    logic [3:0]  t_cfg;
    logic [2:0]  wr_addr;
    logic [15:0] wr_data;
    logic [15:0] leds;
    logic        load_leds;
    logic [3:0]  T;
    logic [2:0]  col_idx;
    logic        period_valid;
`ifdef POV_REVERSE_DIR_EN
    logic        dir;
`endif

    int          cyc = 0;
    int          n_cmp = 0;
    int          n_fail = 0;
    logic [15:0] exp_mem [8];
    strobe_t     strobes [$];
    vec_t        tab [9];
    int          k;

    pov_column_sequencer #(
        .NCOLS(8),
        .CW(3),
        .PW(16),
        .MIN_SLOT(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .index(index),
        .t_cfg(t_cfg),
`ifdef POV_REVERSE_DIR_EN
        .dir(dir),
`endif
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .leds(leds),
        .load_leds(load_leds),
        .T(T),
        .col_idx(col_idx),
        .period_valid(period_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every strobe with the cycle it was seen in.
    always @(negedge clk) begin
        if (load_leds === 1'b1) strobes.push_back({cyc, leds, col_idx, T, period_valid});
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic preload();
        for (int i = 0; i < 8; i++) begin
            wr_en      = 1'b1;
            wr_addr    = 3'(i);
            wr_data    = 16'h0101 << i;
            exp_mem[i] = 16'h0101 << i;
            tick(1);
        end
        wr_en = 1'b0;
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        index = 1'b0;
        wr_en = 1'b0;
        tick(2);
        rst = 1'b0;
    endtask

    // Index rise now, held high three cycles, next rise gap cycles later.
    task automatic rev(input int gap);
        index = 1'b1;
        tick(3);
        index = 1'b0;
        tick(gap - 3);
    endtask

    // Rise at cycle kr gives event at kr+2 and the first strobe at kr+3.
    task automatic check_rev(input string name, input int kr, input int n, input int len,
                             input logic [3:0] t, input logic d);
        logic [2:0] col;
        check({name, " count"}, strobes.size(), n);
        for (int j = 0; j < n && j < strobes.size(); j++) begin
            col = d ? 3'(7 - j) : 3'(j);
            check($sformatf("%s s%0d cycle", name, j), strobes[j].c, kr + 3 + j * len);
            check($sformatf("%s s%0d leds", name, j), strobes[j].leds, exp_mem[col]);
            check($sformatf("%s s%0d col_idx", name, j), strobes[j].col, col);
            check($sformatf("%s s%0d T/pv", name, j), {strobes[j].t, strobes[j].pv}, {t, 1'b1});
        end
    endtask

    initial begin
        tab[0] = '{24, 4'd5, 0, 0, 1'b0};
        tab[1] = '{24, 4'd5, 0, 0, 1'b0};
        tab[2] = '{80, 4'd5, 0, 0, 1'b0};
        tab[3] = '{80, 4'd5, 8, 10, 1'b1};
        tab[4] = '{80, 4'd9, 8, 10, 1'b1};
        tab[5] = '{50, 4'd5, 5, 10, 1'b1};
        tab[6] = '{80, 4'd5, 8, 6, 1'b1};
        tab[7] = '{24, 4'd5, 3, 10, 1'b1};
        tab[8] = '{80, 4'd5, 0, 0, 1'b0};

        rst     = 1'b1;
        index   = 1'b0;
        wr_en   = 1'b0;
        wr_addr = 3'd0;
        wr_data = 16'h0000;
        t_cfg   = 4'd0;
`ifdef POV_REVERSE_DIR_EN
        dir     = 1'b0;
`endif
        preload();
        do_reset();
        check("reset leds", leds, 16'h0000);
        check("reset load_leds", load_leds, 1'b0);
        check("reset T", T, 4'd0);
        check("reset col_idx", col_idx, 3'd0);
        check("reset period_valid", period_valid, 1'b0);

        // Periodic, short-slot, early-index and non-qualifying-in-RUN revolutions.
        for (int i = 0; i < 9; i++) begin
            t_cfg = tab[i].tcfg;
            strobes.delete();
            k = cyc;
            rev(tab[i].gap);
            check_rev($sformatf("vec%0d", i), k, tab[i].n, tab[i].len, tab[i].tcfg, 1'b0);
            check($sformatf("vec%0d period_valid", i), period_valid, tab[i].pv);
        end

        // Index stalls after a revolution: counter saturation drops back to IDLE.
        do_reset();
        t_cfg = 4'd7;
        rev(80);
        strobes.delete();
        k = cyc;
        rev(80);
        check_rev("stall rev", k, 8, 10, 4'd7, 1'b0);
        strobes.delete();
        tick(65530 - 80);
        check("stall pv before sat", period_valid, 1'b1);
        tick(15);
        check("stall pv after sat", period_valid, 1'b0);
        check("stall leds held", leds, 16'h8080);
        check("stall col_idx", col_idx, 3'd0);
        check("stall no strobes", strobes.size(), 0);
        t_cfg = 4'd3;
        rev(80);
        strobes.delete();
        k = cyc;
        rev(80);
        check_rev("resume", k, 8, 10, 4'd3, 1'b0);
        check("resume pv", period_valid, 1'b1);

        // Reset pulsed 25 cycles after the event of a running revolution.
        do_reset();
        t_cfg = 4'd5;
        rev(80);
        strobes.delete();
        k = cyc;
        index = 1'b1;
        tick(3);
        index = 1'b0;
        tick(24);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("midrst leds", leds, 16'h0000);
        check("midrst load_leds", load_leds, 1'b0);
        check("midrst T", T, 4'd0);
        check("midrst col_idx", col_idx, 3'd0);
        check("midrst period_valid", period_valid, 1'b0);
        tick(72);
        check_rev("midrst", k, 3, 10, 4'd5, 1'b0);
        rev(80);
        strobes.delete();
        k = cyc;
        rev(80);
        check_rev("ram kept", k, 8, 10, 4'd5, 1'b0);

        // Write to column 3 in the very cycle it is read.
        do_reset();
        t_cfg = 4'd2;
        rev(80);
        strobes.delete();
        k = cyc;
        index = 1'b1;
        tick(3);
        index = 1'b0;
        tick(29);
        wr_en   = 1'b1;
        wr_addr = 3'd3;
        wr_data = 16'hBEEF;
        tick(1);
        wr_en = 1'b0;
        tick(80 - 33);
        check_rev("collide old", k, 8, 10, 4'd2, 1'b0);
        exp_mem[3] = 16'hBEEF;
        strobes.delete();
        k = cyc;
        rev(80);
        check_rev("collide new", k, 8, 10, 4'd2, 1'b0);

`ifdef POV_REVERSE_DIR_EN
        // Descending column order.
        preload();
        dir = 1'b1;
        do_reset();
        t_cfg = 4'd6;
        rev(80);
        strobes.delete();
        k = cyc;
        rev(80);
        check_rev("reverse", k, 8, 10, 4'd6, 1'b1);
        dir = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
